fetch_queue: RTL and testbench

- Instruction buffer directly downstream of the stage-4 cacheline parser; consumes its per-cycle payload, enable, tag, index and offset.
- Buffers parsed instructions in a circular FIFO and presents them to the decoders in order through a valid/ready handshake.
- Reconstructs each instruction's 64-bit fetch address.
- Drives a stall back to the fetch stages when nearly full; empties on pipeline flush.

---
 rtl/fetch_queue_if.sv | 36 +++
 rtl/fetch_queue.sv | 78 +++++++
 tb/tb_fetch_queue.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Bundle between the cacheline parser, the fetch queue and the decoders.
// The master side drives pushes, flush and decoder ready; the slave side is the queue.
interface fetch_queue_if #(
    parameter int unsigned offsetSize      = 5,
    parameter int unsigned indexSize       = 8,
    parameter int unsigned tagSize         = 64 - (offsetSize + indexSize),
    parameter int unsigned payloadSizeBits = 32,
    parameter int unsigned depthLog2       = 3
);
    logic                       flushPipeline_i;
    logic                       enable_i;
    logic [payloadSizeBits-1:0] instruction_i;
    logic [tagSize-1:0]         tag_i;
    logic [indexSize-1:0]       index_i;
    logic [offsetSize-1:0]      offset_i;
    logic                       decodeReady_i;

    logic                       valid_o;
    logic [payloadSizeBits-1:0] instruction_o;
    logic [63:0]                address_o;
    logic                       stall_o;
    logic [depthLog2:0]         count_o;
    logic                       overflow_o;

    modport master (
        output flushPipeline_i, enable_i, instruction_i, tag_i, index_i, offset_i,
               decodeReady_i,
        input  valid_o, instruction_o, address_o, stall_o, count_o, overflow_o
    );

    modport slave (
        input  flushPipeline_i, enable_i, instruction_i, tag_i, index_i, offset_i,
               decodeReady_i,
        output valid_o, instruction_o, address_o, stall_o, count_o, overflow_o
    );
endinterface

// File: rtl/fetch_queue.sv
// Circular instruction buffer between the cacheline parser and the decoders,
// with show-ahead head output, early stall and a sticky overflow flag.
module fetch_queue #(
    parameter int unsigned offsetSize      = 5,
    parameter int unsigned indexSize       = 8,
    parameter int unsigned tagSize         = 64 - (offsetSize + indexSize),
    parameter int unsigned payloadSizeBits = 32,
    parameter int unsigned depthLog2       = 3,
    parameter int unsigned stallLevel      = 6
) (
    input logic          clock_i,
    input logic          reset_i,
    fetch_queue_if.slave fq
);
    localparam int unsigned depth  = 1 << depthLog2;
    localparam int unsigned CNT_W  = depthLog2 + 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(depth);
    localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(stallLevel);

    logic [payloadSizeBits-1:0] instMem [depth];
    logic [63:0]                addrMem [depth];

    logic [depthLog2-1:0] head;
    logic [depthLog2-1:0] tail;
    logic [CNT_W-1:0]     count;
    logic                 overflow;

    logic empty;
    logic full;
    logic push;
    logic pop;
    logic drop;

    always_comb begin
        empty = (count == '0);
        full  = (count == FULL_CNT);
        pop   = !empty && fq.decodeReady_i;
        // A full queue still accepts a push when the head leaves the same cycle.
        push  = fq.enable_i && (!full || pop);
        drop  = fq.enable_i && full && !pop;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (fq.flushPipeline_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (drop) overflow <= 1'b1;
        end
    end

    // Storage carries no reset; pointers alone define which entries are live.
    always_ff @(posedge clock_i) begin
        if (!reset_i && !fq.flushPipeline_i && push) begin
            instMem[tail] <= fq.instruction_i;
            addrMem[tail] <= {fq.tag_i, fq.index_i, fq.offset_i};
        end
    end

    always_comb begin
        fq.valid_o       = !empty;
        fq.instruction_o = empty ? '0 : instMem[head];
        fq.address_o     = empty ? '0 : addrMem[head];
        fq.stall_o       = (count >= STALL_CNT);
        fq.count_o       = count;
        fq.overflow_o    = overflow;
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, single push, fill/overflow, flush,
// full push+pop and pointer wrap, all against hand-computed values.
module tb_fetch_queue;
    localparam int unsigned OFF_W = 5;
    localparam int unsigned IDX_W = 8;
    localparam int unsigned TAG_W = 64 - (OFF_W + IDX_W);

    logic clock_i = 1'b0;
    logic reset_i = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    always #5 clock_i = ~clock_i;

    fetch_queue_if #(
        .offsetSize(OFF_W), .indexSize(IDX_W), .tagSize(TAG_W),
        .payloadSizeBits(32), .depthLog2(3)
    ) fq ();

    fetch_queue #(
        .offsetSize(OFF_W), .indexSize(IDX_W), .tagSize(TAG_W),
        .payloadSizeBits(32), .depthLog2(3), .stallLevel(6)
    ) dut (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .fq      (fq.slave)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic drive(input logic en, input logic [31:0] ins, input logic [TAG_W-1:0] tg,
                         input logic [IDX_W-1:0] ix, input logic [OFF_W-1:0] of,
                         input logic rdy, input logic fl);
        fq.enable_i        = en;
        fq.instruction_i   = ins;
        fq.tag_i           = tg;
        fq.index_i         = ix;
        fq.offset_i        = of;
        fq.decodeReady_i   = rdy;
        fq.flushPipeline_i = fl;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        idle();
        reset_i = 1'b1;
        step();
        step();
        reset_i = 1'b0;
    endtask

    initial begin
        logic [TAG_W-1:0] tg;
        idle();

        // Reset then idle
        do_reset();
        check("rst_valid", 64'(fq.valid_o), 64'd0);
        check("rst_count", 64'(fq.count_o), 64'd0);
        check("rst_stall", 64'(fq.stall_o), 64'd0);
        check("rst_ovf",   64'(fq.overflow_o), 64'd0);
        check("rst_instr", 64'(fq.instruction_o), 64'd0);
        check("rst_addr",  fq.address_o, 64'd0);

        // Single push: no same-cycle bypass, visible next cycle
        tg = 1;
        drive(1'b1, 32'h38600001, tg, 8'h02, 5'h04, 1'b0, 1'b0);
        check("sp_nobypass", 64'(fq.valid_o), 64'd0);
        step();
        idle();
        check("sp_valid", 64'(fq.valid_o), 64'd1);
        check("sp_instr", 64'(fq.instruction_o), 64'h38600001);
        check("sp_addr",  fq.address_o, 64'h0000000000002044);
        check("sp_count", 64'(fq.count_o), 64'd1);
        fq.decodeReady_i = 1'b1;
        step();
        idle();
        check("sp_popped", 64'(fq.valid_o), 64'd0);
        check("sp_cnt0",   64'(fq.count_o), 64'd0);
        // Ready while empty does nothing
        fq.decodeReady_i = 1'b1;
        step();
        idle();
        check("empty_pop_cnt", 64'(fq.count_o), 64'd0);

        // Fill, stall, overflow
        for (int k = 0; k < 9; k++) begin
            tg = TAG_W'(k);
            drive(1'b1, 32'(k), tg, '0, '0, 1'b0, 1'b0);
            check($sformatf("fill_cnt%0d", k), 64'(fq.count_o), 64'((k > 8) ? 8 : k));
            check($sformatf("fill_stall%0d", k), 64'(fq.stall_o), 64'((k >= 6) ? 1 : 0));
            step();
        end
        idle();
        check("fill_count8", 64'(fq.count_o), 64'd8);
        check("fill_ovf",    64'(fq.overflow_o), 64'd1);
        for (int k = 0; k < 8; k++) begin
            fq.decodeReady_i = 1'b1;
            check($sformatf("drain_valid%0d", k), 64'(fq.valid_o), 64'd1);
            check($sformatf("drain_instr%0d", k), 64'(fq.instruction_o), 64'(k));
            check($sformatf("drain_addr%0d", k), fq.address_o, 64'(k) << 13);
            step();
        end
        idle();
        check("drain_empty", 64'(fq.valid_o), 64'd0);
        check("drain_ovf_sticky", 64'(fq.overflow_o), 64'd1);

        // Flush mid-stream with overflow already set
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'h300 + 32'(k), '0, '0, '0, 1'b0, 1'b0);
            step();
        end
        idle();
        check("fl_count5", 64'(fq.count_o), 64'd5);
        drive(1'b1, 32'hDEAD, '0, '0, '0, 1'b1, 1'b1);
        step();
        idle();
        check("fl_count", 64'(fq.count_o), 64'd0);
        check("fl_valid", 64'(fq.valid_o), 64'd0);
        check("fl_stall", 64'(fq.stall_o), 64'd0);
        check("fl_ovf",   64'(fq.overflow_o), 64'd1);
        tg = 3;
        drive(1'b1, 32'h3AA, tg, 8'h10, 5'h1F, 1'b0, 1'b0);
        step();
        idle();
        check("fl_next_valid", 64'(fq.valid_o), 64'd1);
        check("fl_next_instr", 64'(fq.instruction_o), 64'h3AA);
        check("fl_next_addr",  fq.address_o, 64'h000000000000621F);
        check("fl_next_count", 64'(fq.count_o), 64'd1);

        // Full with simultaneous push and pop
        do_reset();
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 32'h100 + 32'(k), '0, '0, '0, 1'b0, 1'b0);
            step();
        end
        drive(1'b1, 32'h1FF, '0, '0, '0, 1'b1, 1'b0);
        step();
        idle();
        check("fpp_count", 64'(fq.count_o), 64'd8);
        check("fpp_ovf",   64'(fq.overflow_o), 64'd0);
        for (int k = 1; k < 9; k++) begin
            fq.decodeReady_i = 1'b1;
            check($sformatf("fpp_instr%0d", k), 64'(fq.instruction_o),
                  (k == 8) ? 64'h1FF : 64'h100 + 64'(k));
            step();
        end
        idle();
        check("fpp_empty", 64'(fq.valid_o), 64'd0);

        // Wrap-around: 3-entry pre-fill, then 20 cycles of push+pop
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h200 + 32'(k), '0, '0, '0, 1'b0, 1'b0);
            step();
        end
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 32'h203 + 32'(k), '0, '0, '0, 1'b1, 1'b0);
            check($sformatf("wrap_instr%0d", k), 64'(fq.instruction_o), 64'h200 + 64'(k));
            check($sformatf("wrap_cnt%0d", k), 64'(fq.count_o), 64'd3);
            step();
        end
        for (int k = 20; k < 23; k++) begin
            drive(1'b0, '0, '0, '0, '0, 1'b1, 1'b0);
            check($sformatf("wrap_tail%0d", k), 64'(fq.instruction_o), 64'h200 + 64'(k));
            step();
        end
        idle();
        check("wrap_empty", 64'(fq.valid_o), 64'd0);
        check("wrap_ovf",   64'(fq.overflow_o), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
